// File: rtl/tx_frame_scheduler_pkg.sv
// rtl/tx_frame_scheduler_pkg.sv - shared state and grant encodings for tx_frame_scheduler
package tx_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter2.sv
// rtl/tx_frame_scheduler_rr_arbiter2.sv - two-requester round-robin arbiter with update enable
module rr_arbiter2
    import tx_frame_scheduler_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic req_a,
    input  logic req_b,
    input  logic update_en,
    output logic gnt_valid,
    output logic gnt
);

    // ptr names the requester that wins a tie
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_valid = req_a | req_b;
        if (req_a && req_b) begin
            gnt = ptr_q;
        end else if (req_b) begin
            gnt = GNT_B;
        end else begin
            gnt = GNT_A;
        end
        ptr_d = ptr_q;
        if (update_en && gnt_valid) begin
            ptr_d = ~gnt;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= GNT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - arbitrates byte/word sources and sequences bytes into the UART handshake
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [2*DATA_WIDTH-1:0] b_data,
    output logic                    b_ready,
    input  logic                    cfg_parity_en,
    input  logic                    cfg_parity_type,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_data_valid,
    output logic                    tx_parity_en,
    output logic                    tx_parity_type,
    output logic                    sched_busy,
    output logic                    err_timeout
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              bytes_left_q, bytes_left_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0]   hi_byte_q, hi_byte_d;
    logic                    a_ready_q, a_ready_d;
    logic                    b_ready_q, b_ready_d;
    logic                    tx_data_valid_q, tx_data_valid_d;
    logic                    tx_parity_en_q, tx_parity_en_d;
    logic                    tx_parity_type_q, tx_parity_type_d;
    logic                    sched_busy_q, sched_busy_d;
    logic                    err_timeout_q, err_timeout_d;

    logic gnt_valid;
    logic gnt;

    rr_arbiter2 u_arb (
        .CLK       (CLK),
        .Reset     (Reset),
        .req_a     (a_valid),
        .req_b     (b_valid),
        .update_en (state_q == IDLE),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bytes_left_d     = bytes_left_q;
        tx_data_d        = tx_data_q;
        hi_byte_d        = hi_byte_q;
        tx_parity_en_d   = tx_parity_en_q;
        tx_parity_type_d = tx_parity_type_q;
        a_ready_d        = 1'b0;
        b_ready_d        = 1'b0;
        tx_data_valid_d  = 1'b0;
        err_timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d          = SEND;
                    tx_data_valid_d  = 1'b1;
                    tx_parity_en_d   = cfg_parity_en;
                    tx_parity_type_d = cfg_parity_type;
                    if (gnt == GNT_A) begin
                        a_ready_d    = 1'b1;
                        tx_data_d    = a_data;
                        bytes_left_d = 2'd1;
                    end else begin
                        b_ready_d    = 1'b1;
                        tx_data_d    = b_data[DATA_WIDTH-1:0];
                        hi_byte_d    = b_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        bytes_left_d = 2'd2;
                    end
                end
            end
            SEND: begin
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 2)) begin
                    // the increment would reach ACK_TIMEOUT-1: give up on this frame
                    err_timeout_d = 1'b1;
                    bytes_left_d  = 2'd0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (bytes_left_q == 2'd2) begin
                        tx_data_d       = hi_byte_q;
                        bytes_left_d    = 2'd1;
                        tx_data_valid_d = 1'b1;
                        state_d         = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sched_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            bytes_left_q     <= 2'd0;
            tx_data_q        <= '0;
            hi_byte_q        <= '0;
            a_ready_q        <= 1'b0;
            b_ready_q        <= 1'b0;
            tx_data_valid_q  <= 1'b0;
            tx_parity_en_q   <= 1'b0;
            tx_parity_type_q <= 1'b0;
            sched_busy_q     <= 1'b0;
            err_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bytes_left_q     <= bytes_left_d;
            tx_data_q        <= tx_data_d;
            hi_byte_q        <= hi_byte_d;
            a_ready_q        <= a_ready_d;
            b_ready_q        <= b_ready_d;
            tx_data_valid_q  <= tx_data_valid_d;
            tx_parity_en_q   <= tx_parity_en_d;
            tx_parity_type_q <= tx_parity_type_d;
            sched_busy_q     <= sched_busy_d;
            err_timeout_q    <= err_timeout_d;
        end
    end

    assign a_ready        = a_ready_q;
    assign b_ready        = b_ready_q;
    assign tx_data        = tx_data_q;
    assign tx_data_valid  = tx_data_valid_q;
    assign tx_parity_en   = tx_parity_en_q;
    assign tx_parity_type = tx_parity_type_q;
    assign sched_busy     = sched_busy_q;
    assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - randomized and directed bench for tx_frame_scheduler with frame-level model
module tb_tx_frame_scheduler;

    localparam int T = 8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        a_valid = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = 16'h0000;
    logic        b_ready;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_type = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_data_valid, tx_parity_en, tx_parity_type, sched_busy, err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit uart_stuck = 1'b0;
    int uart_rise = 2;
    int uart_hold = 11;

    logic [7:0]  a_q[$];
    logic [15:0] b_q[$];

    int l_byte[$], l_pen[$], l_ptype[$], l_cyc[$];
    int g_port[$], err_cyc[$], bfall_cyc[$], sfall_cyc[$];

    bit         e_a_ready = 0, e_b_ready = 0, e_valid = 0, e_pen = 0, e_ptype = 0, e_sbusy = 0, e_err = 0;
    logic [7:0] e_tx_data = 8'h00;

    tx_frame_scheduler #(.DATA_WIDTH(8), .ACK_TIMEOUT(T)) dut (
        .CLK(CLK), .Reset(Reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_parity_en(tx_parity_en), .tx_parity_type(tx_parity_type),
        .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    initial forever #5 CLK = ~CLK;
    initial forever begin @(posedge CLK); cyc = cyc + 1; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Requesters: present queued items in order, advance on each ready pulse
    initial begin : src_a
        int idx;
        idx = 0;
        forever begin
            @(posedge CLK); #2;
            if (a_ready === 1'b1) idx++;
            a_valid = (idx < a_q.size());
            a_data  = a_valid ? a_q[idx] : 8'h00;
        end
    end

    initial begin : src_b
        int idx;
        idx = 0;
        forever begin
            @(posedge CLK); #2;
            if (b_ready === 1'b1) idx++;
            b_valid = (idx < b_q.size());
            b_data  = b_valid ? b_q[idx] : 16'h0000;
        end
    end

    // UART: Busy rises uart_rise cycles after a launch pulse and stays high uart_hold cycles
    initial begin : uart
        int rise;
        int hold_left;
        rise = -1;
        hold_left = 0;
        forever begin
            @(posedge CLK); #2;
            if (!Reset) begin
                tx_busy = 1'b0; rise = -1; hold_left = 0;
            end else begin
                if (tx_busy) begin
                    hold_left--;
                    if (hold_left <= 0) tx_busy = 1'b0;
                end
                if (rise > 0) begin
                    rise--;
                    if (rise == 0) begin tx_busy = 1'b1; hold_left = uart_hold; rise = -1; end
                end
                if (tx_data_valid === 1'b1 && !uart_stuck) rise = uart_rise;
            end
        end
    end

    // Frame-level model: a frame is a queue of bytes; each launched byte is acked
    // if Busy is seen from the 2nd edge after launch up to the T-th, then done on Busy low.
    initial begin : model
        bit busy, last_b, acked, take_b;
        int since;
        logic [7:0] frame[$];
        busy = 0; last_b = 1; acked = 0; since = 0;
        forever begin
            @(posedge CLK or negedge Reset);
            if (!Reset) begin
                busy = 0; last_b = 1; acked = 0; since = 0; frame.delete();
                e_a_ready = 0; e_b_ready = 0; e_valid = 0; e_err = 0;
                e_pen = 0; e_ptype = 0; e_sbusy = 0; e_tx_data = 8'h00;
            end else begin
                e_a_ready = 0; e_b_ready = 0; e_valid = 0; e_err = 0;
                if (!busy) begin
                    if (a_valid || b_valid) begin
                        take_b = b_valid && (!a_valid || !last_b);
                        last_b = take_b;
                        frame.delete();
                        if (take_b) begin
                            e_b_ready = 1;
                            frame.push_back(b_data[7:0]);
                            frame.push_back(b_data[15:8]);
                        end else begin
                            e_a_ready = 1;
                            frame.push_back(a_data);
                        end
                        e_pen = cfg_parity_en; e_ptype = cfg_parity_type;
                        e_tx_data = frame.pop_front(); e_valid = 1;
                        since = 0; acked = 0; busy = 1;
                    end
                end else begin
                    since++;
                    if (!acked) begin
                        if (since >= 2 && tx_busy) acked = 1;
                        else if (since == T) begin e_err = 1; frame.delete(); busy = 0; end
                    end else if (!tx_busy) begin
                        if (frame.size() > 0) begin
                            e_tx_data = frame.pop_front(); e_valid = 1; since = 0; acked = 0;
                        end else begin
                            busy = 0;
                        end
                    end
                end
                e_sbusy = busy;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge CLK);
            chk("a_ready", a_ready, e_a_ready);
            chk("b_ready", b_ready, e_b_ready);
            chk("tx_data_valid", tx_data_valid, e_valid);
            chk("tx_data", tx_data, e_tx_data);
            chk("tx_parity_en", tx_parity_en, e_pen);
            chk("tx_parity_type", tx_parity_type, e_ptype);
            chk("sched_busy", sched_busy, e_sbusy);
            chk("err_timeout", err_timeout, e_err);
        end
    end

    initial begin : recorder
        bit pb, ps;
        pb = 0; ps = 0;
        forever begin
            @(negedge CLK);
            if (tx_data_valid === 1'b1) begin
                l_byte.push_back(int'(tx_data)); l_pen.push_back(int'(tx_parity_en));
                l_ptype.push_back(int'(tx_parity_type)); l_cyc.push_back(cyc);
            end
            if (a_ready === 1'b1) g_port.push_back(0);
            if (b_ready === 1'b1) g_port.push_back(1);
            if (err_timeout === 1'b1) err_cyc.push_back(cyc);
            if (pb && tx_busy === 1'b0) bfall_cyc.push_back(cyc);
            if (ps && sched_busy === 1'b0) sfall_cyc.push_back(cyc);
            pb = (tx_busy === 1'b1);
            ps = (sched_busy === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge CLK); #3;
            if (!sched_busy && !tx_busy && !a_valid && !b_valid) done = 1;
        end
        chk({tag, "_idle_reached"}, done, 1);
        repeat (2) @(posedge CLK);
        #3;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_valid"}, tx_data_valid, 0);
        chk({tag, "_par_en"}, tx_parity_en, 0);
        chk({tag, "_par_type"}, tx_parity_type, 0);
        chk({tag, "_sched_busy"}, sched_busy, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin : main
        int l0, g0, f0, s0, e0;
        bit seen;
        repeat (3) @(posedge CLK);
        #3;
        chk_zero("reset");
        Reset = 1'b1;

        // single byte on Port A
        l0 = l_cyc.size(); g0 = g_port.size(); f0 = bfall_cyc.size(); s0 = sfall_cyc.size();
        a_q.push_back(8'hA5);
        wait_idle("porta", 100);
        chk("porta_grants", g_port.size() - g0, 1);
        chk("porta_port", qi(g_port, g0), 0);
        chk("porta_launches", l_cyc.size() - l0, 1);
        chk("porta_byte", qi(l_byte, l0), 32'hA5);
        chk("porta_sbusy_lag", qi(sfall_cyc, s0) - qi(bfall_cyc, f0), 1);

        // word on Port B, low byte first
        l0 = l_cyc.size(); g0 = g_port.size(); f0 = bfall_cyc.size();
        b_q.push_back(16'h3C7E);
        wait_idle("portb", 150);
        chk("portb_grants", g_port.size() - g0, 1);
        chk("portb_port", qi(g_port, g0), 1);
        chk("portb_launches", l_cyc.size() - l0, 2);
        chk("portb_byte0", qi(l_byte, l0), 32'h7E);
        chk("portb_byte1", qi(l_byte, l0 + 1), 32'h3C);
        chk("portb_gap", qi(l_cyc, l0 + 1) - qi(bfall_cyc, f0), 1);

        // both ports held: alternate, A first since B won last
        g0 = g_port.size();
        a_q.push_back(8'h01); a_q.push_back(8'h02);
        b_q.push_back(16'h0B01); b_q.push_back(16'h0B02);
        wait_idle("rr", 600);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), qi(g_port, g0 + i), i % 2);

        // parity sampled at accept, toggling mid-frame has no effect
        cfg_parity_en = 1'b1; cfg_parity_type = 1'b0;
        l0 = l_cyc.size();
        b_q.push_back(16'h55AA);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge CLK); #3;
            if (l_cyc.size() > l0 || tx_data_valid) seen = 1;
        end
        chk("par_first_launch_seen", seen, 1);
        cfg_parity_en = 1'b0; cfg_parity_type = 1'b1;
        wait_idle("par", 150);
        chk("par_launches", l_cyc.size() - l0, 2);
        chk("par_en_b0", qi(l_pen, l0), 1);
        chk("par_type_b0", qi(l_ptype, l0), 0);
        chk("par_en_b1", qi(l_pen, l0 + 1), 1);
        chk("par_type_b1", qi(l_ptype, l0 + 1), 0);
        chk("par_held_after", tx_parity_en, 1);

        // transmitter never acknowledges
        uart_stuck = 1;
        l0 = l_cyc.size(); e0 = err_cyc.size();
        b_q.push_back(16'hC0DE);
        wait_idle("tmo", 100);
        chk("tmo_err_count", err_cyc.size() - e0, 1);
        chk("tmo_err_delay", qi(err_cyc, e0) - qi(l_cyc, l0), T);
        chk("tmo_launches", l_cyc.size() - l0, 1);
        chk("tmo_byte", qi(l_byte, l0), 32'hDE);
        uart_stuck = 0;
        l0 = l_cyc.size();
        a_q.push_back(8'h5A);
        wait_idle("tmo_next", 100);
        chk("tmo_next_launches", l_cyc.size() - l0, 1);
        chk("tmo_next_byte", qi(l_byte, l0), 32'h5A);
        chk("tmo_next_no_err", err_cyc.size() - e0, 1);

        // reset during WAIT_DONE of a word, held b_valid re-accepted after release
        b_q.push_back(16'h1234); b_q.push_back(16'hBEEF);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge CLK); #3;
            if (tx_busy) seen = 1;
        end
        chk("rwd_busy_seen", seen, 1);
        repeat (3) @(posedge CLK);
        #3;
        Reset = 1'b0;
        #1;
        chk_zero("rwd");
        repeat (3) @(posedge CLK);
        #3;
        l0 = l_cyc.size(); g0 = g_port.size();
        Reset = 1'b1;
        wait_idle("rwd", 150);
        chk("rwd_grants", g_port.size() - g0, 1);
        chk("rwd_port", qi(g_port, g0), 1);
        chk("rwd_launches", l_cyc.size() - l0, 2);
        chk("rwd_byte0", qi(l_byte, l0), 32'hEF);
        chk("rwd_byte1", qi(l_byte, l0 + 1), 32'hBE);

        // after reset, a tie goes to A
        @(posedge CLK); #3;
        Reset = 1'b0;
        a_q.push_back(8'h77); b_q.push_back(16'h8899);
        repeat (3) @(posedge CLK);
        #3;
        l0 = l_cyc.size(); g0 = g_port.size();
        Reset = 1'b1;
        wait_idle("rfirst", 200);
        chk("rfirst_grant0", qi(g_port, g0), 0);
        chk("rfirst_grant1", qi(g_port, g0 + 1), 1);
        chk("rfirst_byte0", qi(l_byte, l0), 32'h77);
        chk("rfirst_byte1", qi(l_byte, l0 + 1), 32'h99);
        chk("rfirst_byte2", qi(l_byte, l0 + 2), 32'h88);

        // randomized traffic, UART timing and parity config
        for (int i = 0; i < 800; i++) begin
            @(posedge CLK); #3;
            if ($urandom_range(0, 11) == 0) a_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 11) == 0) b_q.push_back(16'($urandom_range(0, 65535)));
            cfg_parity_en   = 1'($urandom_range(0, 1));
            cfg_parity_type = 1'($urandom_range(0, 1));
            uart_rise  = $urandom_range(1, T - 1);
            uart_hold  = $urandom_range(1, 5);
            uart_stuck = ($urandom_range(0, 15) == 0);
        end
        uart_stuck = 0;
        wait_idle("random", 8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Sits between two on-chip data sources and the 8-bit UART transmitter.
  - Port A is a single byte, e.g. a register-file read result.
  - Port B is a 16-bit word, e.g. an ALU result.
- Arbitrates round-robin, splits words into bytes (low byte first) and sequences each byte through the UART Data_valid/Busy handshake.
- Holds data and parity configuration stable for the whole frame, because the transmitter computes parity combinationally from its data input.
- Detects a transmitter that never acknowledges.

Parameters:
- DATA_WIDTH, 8, UART byte width; Port B word is 2*DATA_WIDTH.
- ACK_TIMEOUT, 8, cycles to wait for Busy to rise after a Data_valid pulse (>=3).

Ports:
- CLK  in  1  clock
- Reset  in  1  asynchronous, active-low reset
- a_valid  in  1  Port A request; held high with a_data until a_ready
- a_data  in  DATA_WIDTH  Port A byte
- a_ready  out  1  one-cycle accept pulse for Port A
- b_valid  in  1  Port B request; held high with b_data until b_ready
- b_data  in  2*DATA_WIDTH  Port B word
- b_ready  out  1  one-cycle accept pulse for Port B
- cfg_parity_en  in  1  parity enable, sampled at accept
- cfg_parity_type  in  1  parity type, sampled at accept
- tx_busy  in  1  UART Busy (registered in the UART)
- tx_data  out  DATA_WIDTH  byte to UART
- tx_data_valid  out  1  one-cycle launch pulse to UART
- tx_parity_en  out  1  latched parity enable to UART
- tx_parity_type  out  1  latched parity type to UART
- sched_busy  out  1  high whenever state is not IDLE
- err_timeout  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- All outputs are registered. On Reset low, all outputs go to 0 immediately, state goes to IDLE, the round-robin pointer favours A, and the timeout counter clears.
- States are IDLE, SEND, WAIT_ACK and WAIT_DONE.
- IDLE:
  - If a_valid or b_valid is high at edge N, grant one requester.
  - If only one is requesting, grant it. If both are requesting, grant the one not granted last.
  - In cycle N+1: the granted x_ready=1 for exactly one cycle, and data is captured.
    - Port A: bytes_left=1.
    - Port B: low byte first, high byte held; bytes_left=2.
  - cfg_parity_* are captured into tx_parity_*. State goes to SEND.
- SEND:
  - tx_data_valid=1 for exactly this cycle and tx_data holds the current byte.
  - Next state is WAIT_ACK; the counter clears.
- WAIT_ACK:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 with tx_busy still 0:
    - err_timeout=1 for one cycle;
    - remaining bytes are discarded;
    - state returns to IDLE.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If bytes_left=2: load the high byte into tx_data, set bytes_left=1, go to SEND.
  - Else go to IDLE.
- tx_data, tx_parity_en and tx_parity_type change only at capture or at the byte advance. They are held through the end of the frame and beyond it until the next capture.
- A cfg_parity_* change after accept has no effect until the next accept. Both bytes of a word use the same parity setting.
- There are no ready pulses outside the IDLE->SEND transition. Stale x_valid in the cycle after x_ready is ignored because the state is not IDLE.
- The round-robin pointer is updated only on a grant.
- Minimum gap between the end of one frame (tx_busy falling) and the next tx_data_valid is 1 cycle for a second byte and 2 cycles for a new request.
- Reset mid-frame aborts immediately. Pending requests are not accepted until IDLE evaluates them after reset release.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, SEND=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3);
  - grant encoding constants GNT_A=1'b0 and GNT_B=1'b1.
- One natural sub-module is rr_arbiter2: a 2-requester round-robin with a pointer register and an update enable. Everything else is inline.

Test Plan:
- Port A, a_data=8'hA5, tx_busy model rising 2 cycles after valid and held 11 cycles:
  - a_ready pulses once;
  - one tx_data_valid with tx_data=8'hA5;
  - sched_busy falls 1 cycle after tx_busy falls.
- Port B, b_data=16'h3C7E:
  - two tx_data_valid pulses, the first with 8'h7E and the second with 8'h3C;
  - the second pulse comes 1 cycle after tx_busy falls;
  - b_ready pulses once.
- a_valid and b_valid both held high with new data each accept:
  - grants alternate A, B, A, B;
  - after reset the first grant is A.
- cfg_parity_en=1 and cfg_parity_type=0 at accept of a word, toggled during the first byte:
  - tx_parity_* stay 1/0 for both bytes.
- tx_busy stuck 0:
  - err_timeout pulses exactly ACK_TIMEOUT cycles after the SEND cycle;
  - the Port B high byte is never sent;
  - the next request is accepted normally.
- Reset asserted during WAIT_DONE of a word:
  - all outputs go to 0 at once;
  - after release, a held b_valid is re-accepted and both bytes are sent.
